tx_gearbox: RTL and testbench
=============================

Name: tx_gearbox

Overview:
- Transmit-side 66b→64b gearbox for the 40GbE PCS lane datapath.
- Accepts one 64b/66b block per cycle (2-bit sync header plus 64-bit scrambled payload) and emits one 64-bit word per cycle to the SERDES.
- Runs a 33-cycle sequence: 32 blocks in, 33 words out. Input is paused for one cycle per sequence.
- Underruns are filled with a fixed error block, so the serial line never stalls.

Parameters:
FILL_SYNC, 2'b10, sync header of the substituted block on underrun
FILL_PAYLOAD, 64'h1E1E1E1E1E1E1E1E, payload of the substituted block (error control block)

Ports:
clk  input  1  lane clock; one block in and one word out per cycle
reset  input  1  asynchronous, active-high
tx_sync  input  2  sync header of the offered block; bit 0 is transmitted first
tx_payload  input  64  payload of the offered block; bit 0 is transmitted first after the header
tx_valid  input  1  offered block is valid
tx_ready  output  1  gearbox consumes a block this cycle
serdes_data  output  64  word to the SERDES; bit 0 is transmitted first
underrun  output  1  one-cycle pulse: tx_ready=1 and tx_valid=0 in the previous cycle
seq  output  6  current sequence position, 0..32 (debug)

Behaviour:
- Block formation: blk[65:0] = {tx_payload, tx_sync}.
- Fill substitution: if tx_ready=1 and tx_valid=0, blk = {FILL_PAYLOAD, FILL_SYNC} and the sequence still advances.
- State:
  - seq counter: 0..32; wraps 32→0 every cycle after reset.
  - Leftover buffer: lo, 64 bits.
  - Before cycle s (s ≤ 32), lo holds exactly 2s valid bits in lo[2s-1:0].
- tx_ready: combinational, tx_ready = (seq != 32). It depends only on state, never on tx_valid.
- Cycle s < 32:
  - Word formed: {blk[63-2s:0], lo[2s-1:0]}.
  - lo ← blk[65:64-2s], i.e. 2s+2 bits right-aligned; upper bits don't-care.
  - seq ← s+1.
- Cycle s = 32:
  - No block consumed; tx_valid and tx_payload are ignored.
  - Word formed: lo[63:0] (the upper 64 bits of block 31, i.e. its payload).
  - lo cleared; seq ← 0.
- Latency: the word formed in cycle t appears on serdes_data at t+1 (registered). Bits of a block consumed at cycle t appear at t+1 and, where split, at t+2.
- underrun: registered, asserted at t+1 for a fill at cycle t. Never asserted for the s=32 pause.
- Reset (asserted at any time, including mid-sequence):
  - serdes_data=0, underrun=0, seq=0, lo=0.
  - tx_ready=1 while in reset; inputs are not consumed while reset is high.
  - First cycle after deassert is s=0 with an empty lo; any partial block is discarded.
- Bit ordering is LSB-first throughout. The sync header always precedes its payload on the line.
- Simultaneous events: none besides reset, which has priority over everything.

Test Plan:
1. Reset/idle: hold reset 5 cycles, tx_valid=0 → serdes_data=0, underrun=0, seq=0, tx_ready=1; after release, underrun pulses every cycle except the cycle following seq=32.
2. Alignment: stream blocks k=0..31 with tx_sync=2'b01, tx_payload=64'h0123456789ABCDEF+k:
   - word 0 = {payload0[61:0], 2'b01};
   - word 1 = {payload1[59:0], 2'b01, payload0[63:62]};
   - word 32 (s=32) = payload31 exactly.
3. Ready cadence: continuous valid for 200 cycles → tx_ready low exactly on cycles where seq=32 (period 33); 6 pauses, 194 blocks consumed.
4. Underrun fill: drop tx_valid at s=5 for one cycle → underrun=1 next cycle; the deserialised stream contains {FILL_PAYLOAD, FILL_SYNC} at block index 5; neighbouring blocks are intact.
5. Reset mid-sequence: assert reset at s=17 for 2 cycles → serdes_data=0 and seq=0 during reset; first word after release = {blk[63:0], nothing}, i.e. blk[63:0] of the first new block.
6. Round-trip: 10,000 random blocks, serialised and re-deserialised by a bench model at 66-bit boundaries → bit-exact match, with no lost or duplicated blocks.

Source files
------------

// File: rtl/tx_gearbox.sv
// Transmit 66b->64b gearbox: 32 blocks in, 33 words out per sequence, LSB-first.
// Missing input blocks are replaced by a fixed error block so the line never stalls.
module tx_gearbox #(
  parameter logic [1:0]  FILL_SYNC    = 2'b10,
  parameter logic [63:0] FILL_PAYLOAD = 64'h1E1E1E1E1E1E1E1E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  tx_sync,
  input  logic [63:0] tx_payload,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [63:0] serdes_data,
  output logic        underrun,
  output logic [5:0]  seq
);

  localparam logic [5:0] LastSeq = 6'd32;

  logic [5:0]   seq_q, seq_d;
  logic [63:0]  lo_q, lo_d;
  logic [63:0]  data_q, data_d;
  logic         underrun_q, underrun_d;
  logic [65:0]  blk;
  logic [6:0]   shamt;
  logic [127:0] shifted;

  always_comb begin
    tx_ready   = (seq_q != LastSeq);
    blk        = tx_valid ? {tx_payload, tx_sync} : {FILL_PAYLOAD, FILL_SYNC};
    shamt      = {seq_q, 1'b0};
    // Block lands above the 2s leftover bits; bits above 64 become the new leftover.
    shifted    = {62'b0, blk} << shamt;
    seq_d      = seq_q;
    lo_d       = lo_q;
    data_d     = data_q;
    underrun_d = 1'b0;
    if (tx_ready) begin
      data_d     = shifted[63:0] | lo_q;
      lo_d       = shifted[127:64];
      seq_d      = seq_q + 6'd1;
      underrun_d = ~tx_valid;
    end else begin
      data_d = lo_q;
      lo_d   = '0;
      seq_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q      <= '0;
      lo_q       <= '0;
      data_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      lo_q       <= lo_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  assign serdes_data = data_q;
  assign underrun    = underrun_q;
  assign seq         = seq_q;

endmodule

// File: tb/tb_tx_gearbox.sv
// Directed bench for tx_gearbox: an independent sequence model plus a 66-bit
// deserialiser that rebuilds blocks from the serial word stream.
module tb_tx_gearbox;

  localparam logic [1:0]  FillSync    = 2'b10;
  localparam logic [63:0] FillPayload = 64'h1E1E1E1E1E1E1E1E;
  localparam logic [63:0] Base        = 64'h0123456789ABCDEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  tx_sync;
  logic [63:0] tx_payload;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] serdes_data;
  logic        underrun;
  logic [5:0]  seq;

  tx_gearbox #(
    .FILL_SYNC    (FillSync),
    .FILL_PAYLOAD (FillPayload)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_sync     (tx_sync),
    .tx_payload  (tx_payload),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .serdes_data (serdes_data),
    .underrun    (underrun),
    .seq         (seq)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned mseq     = 0;
  int unsigned n_cons   = 0;
  int unsigned n_pause  = 0;
  int unsigned n_deser  = 0;
  logic        last_ready;
  logic [63:0] last_word;
  logic [65:0] expq[$];
  logic [63:0] words[$];
  logic [191:0] acc = '0;
  int unsigned acc_n = 0;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic deser(input logic [63:0] w);
    logic [65:0] b;
    logic [65:0] e;
    acc   = acc | ({128'b0, w} << acc_n);
    acc_n = acc_n + 64;
    while (acc_n >= 66) begin
      b     = acc[65:0];
      acc   = acc >> 66;
      acc_n = acc_n - 66;
      e     = (expq.size() > 0) ? expq.pop_front() : 66'h0;
      n_deser++;
      chk($sformatf("block%0d", n_deser), b, e);
    end
  endtask

  // One lane cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic cyc(input logic r, input logic v, input logic [1:0] sy, input logic [63:0] pl);
    logic cons;
    logic exp_ur;
    reset = r; tx_valid = v; tx_sync = sy; tx_payload = pl;
    if (r) mseq = 0;
    #1;
    last_ready = tx_ready;
    chk("tx_ready", {65'b0, tx_ready}, {65'b0, (mseq != 32)});
    chk("seq", {60'b0, seq}, 66'(mseq));
    cons   = !r && (mseq != 32);
    exp_ur = cons && !v;
    if (cons) begin
      expq.push_back(v ? {pl, sy} : {FillPayload, FillSync});
      n_cons++;
    end
    @(posedge clk);
    #1;
    last_word = serdes_data;
    chk("underrun", {65'b0, underrun}, {65'b0, exp_ur});
    if (r) begin
      chk("serdes_rst", {2'b0, serdes_data}, 66'h0);
      expq.delete();
      acc = '0;
      acc_n = 0;
    end else begin
      words.push_back(serdes_data);
      deser(serdes_data);
      mseq = (mseq == 32) ? 0 : mseq + 1;
    end
  endtask

  initial begin
    logic [63:0] p;
    logic [1:0]  s;
    // Reset/idle
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 2'b00, 64'h0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 2'b00, 64'h0);

    // Alignment from a fresh sequence
    cyc(1'b1, 1'b0, 2'b00, 64'h0);
    words.delete();
    for (int k = 0; k < 33; k++) cyc(1'b0, 1'b1, 2'b01, Base + 64'(k));
    p = Base;
    chk("word0", {2'b0, words[0]}, {2'b0, p[61:0], 2'b01});
    chk("word1", {2'b0, words[1]}, {2'b0, p[59:0] + 60'd1, 2'b01, p[63:62]});
    chk("word32", {2'b0, words[32]}, {2'b0, Base + 64'd31});

    // Ready cadence over 200 cycles starting at seq 0
    n_pause = 0;
    n_cons  = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 1'b1, 2'($urandom_range(1, 2)), {$urandom, $urandom});
      if (!last_ready) n_pause++;
    end
    chk("pauses", 66'(n_pause), 66'd6);
    chk("consumed", 66'(n_cons), 66'd194);

    // Underrun at s=5, neighbours checked by the deserialiser
    while (mseq != 5) cyc(1'b0, 1'b1, 2'b01, {$urandom, $urandom});
    cyc(1'b0, 1'b0, 2'b01, 64'hDEAD_BEEF_0000_0005);
    chk("underrun_s5", {65'b0, underrun}, 66'd1);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 2'b10, {$urandom, $urandom});

    // Reset mid-sequence
    while (mseq != 17) cyc(1'b0, 1'b1, 2'b01, {$urandom, $urandom});
    cyc(1'b1, 1'b1, 2'b01, 64'h0);
    cyc(1'b1, 1'b1, 2'b01, 64'h0);
    p = 64'hA5A5_0F0F_3C3C_9696;
    cyc(1'b0, 1'b1, 2'b10, p);
    chk("first_after_rst", {2'b0, last_word}, {2'b0, p[61:0], 2'b10});

    // Round-trip with random blocks and occasional underruns
    n_cons = 0;
    while (n_cons < 10000) begin
      s = 2'($urandom_range(1, 2));
      cyc(1'b0, ($urandom_range(0, 19) != 0), s, {$urandom, $urandom});
    end
    chk("leftover", 66'(expq.size() <= 1), 66'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
